// File: rtl/jtframe_pll_seq.sv
// Reset sequencer for the core PLL: pulses PLL reset, filters lock, then releases
// SDRAM and game resets in order. Any loss of lock after SDRAM release restarts the sequence.
module jtframe_pll_seq #(
    parameter int PLL_RST_CYC = 16,
    parameter int LOCK_FILT   = 1024,
    parameter int SDRAM_DLY   = 256,
    parameter int LOCK_TMO    = 1048576,
    parameter int CW          = 21
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       locked,
    output logic       pll_rst,
    output logic       sdram_rst,
    output logic       game_rst,
    output logic       ready,
    output logic [2:0] st,
    output logic [7:0] relock_cnt,
    output logic [7:0] retry_cnt
);

    typedef enum logic [2:0] {
        RESET_PLL  = 3'd0,
        WAIT_LOCK  = 3'd1,
        FILTER     = 3'd2,
        SDRAM_INIT = 3'd3,
        RUN        = 3'd4
    } state_t;

    localparam logic [CW-1:0] PLL_LAST  = CW'(PLL_RST_CYC - 1);
    localparam logic [CW-1:0] FILT_LAST = CW'(LOCK_FILT - 1);
    localparam logic [CW-1:0] DLY_LAST  = CW'(SDRAM_DLY - 1);
    localparam logic [CW-1:0] TMO_LAST  = CW'(LOCK_TMO - 1);

    state_t        st_reg;
    state_t        st_next;
    logic [CW-1:0] cnt_reg;
    logic          lock_m_reg;
    logic          lock_s_reg;
    logic          relock_inc;
    logic          retry_inc;

    assign st = st_reg;

    always_comb begin
        st_next    = st_reg;
        relock_inc = 1'b0;
        retry_inc  = 1'b0;
        case (st_reg)
            RESET_PLL: begin
                if (cnt_reg == PLL_LAST) st_next = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (lock_s_reg) begin
                    st_next = FILTER;
                end else if (cnt_reg == TMO_LAST) begin
                    st_next   = RESET_PLL;
                    retry_inc = 1'b1;
                end
            end
            FILTER: begin
                // A glitch only restarts the filter window; the PLL is not reset again
                if (!lock_s_reg) st_next = WAIT_LOCK;
                else if (cnt_reg == FILT_LAST) st_next = SDRAM_INIT;
            end
            SDRAM_INIT: begin
                if (!lock_s_reg) begin
                    st_next    = RESET_PLL;
                    relock_inc = 1'b1;
                end else if (cnt_reg == DLY_LAST) begin
                    st_next = RUN;
                end
            end
            RUN: begin
                if (!lock_s_reg) begin
                    st_next    = RESET_PLL;
                    relock_inc = 1'b1;
                end
            end
            default: st_next = RESET_PLL;
        endcase
    end

    // Outputs are decoded from st_next so they change on the same edge as st
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock_m_reg <= 1'b0;
            lock_s_reg <= 1'b0;
            st_reg     <= RESET_PLL;
            cnt_reg    <= '0;
            pll_rst    <= 1'b1;
            sdram_rst  <= 1'b1;
            game_rst   <= 1'b1;
            ready      <= 1'b0;
            relock_cnt <= 8'd0;
            retry_cnt  <= 8'd0;
        end else begin
            lock_m_reg <= locked;
            lock_s_reg <= lock_m_reg;
            st_reg     <= st_next;
            cnt_reg    <= (st_next != st_reg) ? '0 : cnt_reg + 1'b1;
            pll_rst    <= (st_next == RESET_PLL);
            sdram_rst  <= !((st_next == SDRAM_INIT) || (st_next == RUN));
            game_rst   <= (st_next != RUN);
            ready      <= (st_next == RUN);
            if (relock_inc && relock_cnt != 8'hFF) relock_cnt <= relock_cnt + 8'd1;
            if (retry_inc && retry_cnt != 8'hFF) retry_cnt <= retry_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_jtframe_pll_seq.sv
// Directed bench for jtframe_pll_seq: bring-up timing, timeout retry, filter glitch,
// lock loss in RUN, mid-sequence reset and counter saturation.
module tb_jtframe_pll_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       locked;
    logic       pll_rst;
    logic       sdram_rst;
    logic       game_rst;
    logic       ready;
    logic [2:0] st;
    logic [7:0] relock_cnt;
    logic [7:0] retry_cnt;

    int vectors = 0;
    int miscompares = 0;

    jtframe_pll_seq #(
        .PLL_RST_CYC(4),
        .LOCK_FILT  (8),
        .SDRAM_DLY  (6),
        .LOCK_TMO   (32),
        .CW         (21)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .locked    (locked),
        .pll_rst   (pll_rst),
        .sdram_rst (sdram_rst),
        .game_rst  (game_rst),
        .ready     (ready),
        .st        (st),
        .relock_cnt(relock_cnt),
        .retry_cnt (retry_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // The last edge with rst_n low is edge 0 of each scenario
    task automatic do_reset();
        rst_n  = 1'b0;
        locked = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({st, pll_rst, sdram_rst, game_rst, ready, relock_cnt, retry_cnt} !== {3'd0, 4'b1110, 16'd0}) begin
            miscompares++;
            $display("FAIL reset: st=%0d pll=%b sd=%b game=%b rdy=%b relock=%0d retry=%0d required st=0 1110 0 0",
                     st, pll_rst, sdram_rst, game_rst, ready, relock_cnt, retry_cnt);
        end
        $display("reset: st=%0d pll=%b sd=%b game=%b rdy=%b", st, pll_rst, sdram_rst, game_rst, ready);
    endtask

    task automatic test_bringup();
        logic [2:0] exp_st;
        logic [3:0] exp_out;
        do_reset();
        for (int e = 1; e <= 23; e++) begin
            tick();
            if (e < 4) exp_st = 3'd0;
            else if (e < 9) exp_st = 3'd1;
            else if (e < 17) exp_st = 3'd2;
            else if (e < 23) exp_st = 3'd3;
            else exp_st = 3'd4;
            exp_out = {e < 4, e < 17, e < 23, e >= 23};
            vectors++;
            if (st !== exp_st || {pll_rst, sdram_rst, game_rst, ready} !== exp_out) begin
                miscompares++;
                $display("FAIL bringup edge %0d: st=%0d outs=%b required st=%0d outs=%b",
                         e, st, {pll_rst, sdram_rst, game_rst, ready}, exp_st, exp_out);
            end
            if (e == 6) locked = 1'b1;
        end
        $display("bringup: reached st=%0d ready=%b", st, ready);
    endtask

    task automatic test_lock_timeout();
        logic [2:0] exp_st;
        logic [7:0] exp_retry;
        do_reset();
        for (int e = 1; e <= 40; e++) begin
            tick();
            if (e < 4) exp_st = 3'd0;
            else if (e < 36) exp_st = 3'd1;
            else if (e < 40) exp_st = 3'd0;
            else exp_st = 3'd1;
            exp_retry = (e < 36) ? 8'd0 : 8'd1;
            vectors++;
            if (st !== exp_st || pll_rst !== (exp_st == 3'd0) || retry_cnt !== exp_retry) begin
                miscompares++;
                $display("FAIL timeout edge %0d: st=%0d pll=%b retry=%0d required st=%0d pll=%b retry=%0d",
                         e, st, pll_rst, retry_cnt, exp_st, exp_st == 3'd0, exp_retry);
            end
        end
        $display("timeout: retry_cnt=%0d", retry_cnt);
    endtask

    task automatic test_filter_glitch();
        logic [2:0] exp_st;
        do_reset();
        locked = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (e < 4) exp_st = 3'd0;
            else if (e == 4) exp_st = 3'd1;
            else if (e <= 10) exp_st = 3'd2;
            else if (e == 11) exp_st = 3'd1;
            else if (e <= 19) exp_st = 3'd2;
            else exp_st = 3'd3;
            vectors++;
            if (st !== exp_st || pll_rst !== (e < 4) || relock_cnt !== 8'd0 || retry_cnt !== 8'd0) begin
                miscompares++;
                $display("FAIL glitch edge %0d: st=%0d pll=%b relock=%0d retry=%0d required st=%0d pll=%b 0 0",
                         e, st, pll_rst, relock_cnt, retry_cnt, exp_st, e < 4);
            end
            if (e == 8) locked = 1'b0;
            if (e == 9) locked = 1'b1;
        end
        $display("glitch: st=%0d after filter restart", st);
    endtask

    task automatic test_loss_run();
        logic [2:0] exp_st;
        logic [3:0] exp_out;
        logic [7:0] exp_relock;
        do_reset();
        locked = 1'b1;
        for (int e = 1; e <= 44; e++) begin
            tick();
            if (e < 4) exp_st = 3'd0;
            else if (e == 4) exp_st = 3'd1;
            else if (e <= 12) exp_st = 3'd2;
            else if (e <= 18) exp_st = 3'd3;
            else if (e <= 24) exp_st = 3'd4;
            else if (e <= 28) exp_st = 3'd0;
            else if (e == 29) exp_st = 3'd1;
            else if (e <= 37) exp_st = 3'd2;
            else if (e <= 43) exp_st = 3'd3;
            else exp_st = 3'd4;
            exp_out    = {exp_st == 3'd0, exp_st < 3'd3, exp_st != 3'd4, exp_st == 3'd4};
            exp_relock = (e < 25) ? 8'd0 : 8'd1;
            vectors++;
            if (st !== exp_st || {pll_rst, sdram_rst, game_rst, ready} !== exp_out || relock_cnt !== exp_relock) begin
                miscompares++;
                $display("FAIL loss_run edge %0d: st=%0d outs=%b relock=%0d required st=%0d outs=%b relock=%0d",
                         e, st, {pll_rst, sdram_rst, game_rst, ready}, relock_cnt, exp_st, exp_out, exp_relock);
            end
            if (e == 22) locked = 1'b0;
            if (e == 26) locked = 1'b1;
        end
        $display("loss_run: relock_cnt=%0d st=%0d", relock_cnt, st);
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        n = 0;
        while (retry_cnt !== 8'd1 && n < 100) begin tick(); n++; end
        locked = 1'b1;
        n = 0;
        while (st !== 3'd3 && n < 100) begin tick(); n++; end
        locked = 1'b0;
        n = 0;
        while (st !== 3'd0 && n < 10) begin tick(); n++; end
        locked = 1'b1;
        n = 0;
        while (st !== 3'd3 && n < 100) begin tick(); n++; end
        tick();
        tick();
        vectors++;
        if (st !== 3'd3 || relock_cnt !== 8'd1 || retry_cnt !== 8'd1 || sdram_rst !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid setup: st=%0d relock=%0d retry=%0d sd=%b required st=3 relock=1 retry=1 sd=0",
                     st, relock_cnt, retry_cnt, sdram_rst);
        end
        rst_n = 1'b0;
        tick();
        vectors++;
        if ({st, pll_rst, sdram_rst, game_rst, ready, relock_cnt, retry_cnt} !== {3'd0, 4'b1110, 16'd0}) begin
            miscompares++;
            $display("FAIL reset_mid: st=%0d pll=%b sd=%b game=%b rdy=%b relock=%0d retry=%0d required st=0 1110 0 0",
                     st, pll_rst, sdram_rst, game_rst, ready, relock_cnt, retry_cnt);
        end
        rst_n = 1'b1;
        $display("reset_mid: st=%0d relock=%0d retry=%0d", st, relock_cnt, retry_cnt);
    endtask

    task automatic test_saturation();
        int n;
        int timeouts;
        do_reset();
        locked   = 1'b1;
        timeouts = 0;
        for (int i = 1; i <= 260; i++) begin
            n = 0;
            while (ready !== 1'b1 && n < 100) begin tick(); n++; end
            if (ready !== 1'b1) timeouts++;
            locked = 1'b0;
            n = 0;
            while (st !== 3'd0 && n < 10) begin tick(); n++; end
            locked = 1'b1;
            if (i == 255 || i == 260) begin
                vectors++;
                if (relock_cnt !== 8'd255) begin
                    miscompares++;
                    $display("FAIL relock_sat after %0d losses: relock=%0d required 255", i, relock_cnt);
                end
            end
        end
        vectors++;
        if (timeouts != 0) begin
            miscompares++;
            $display("FAIL relock_sat wait: %0d expired waits required 0", timeouts);
        end
        locked = 1'b0;
        tick();
        for (int i = 1; i <= 260; i++) begin
            n = 0;
            while (st !== 3'd1 && n < 10) begin tick(); n++; end
            n = 0;
            while (st !== 3'd0 && n < 40) begin tick(); n++; end
            if (i == 254) begin
                vectors++;
                if (retry_cnt !== 8'd254) begin
                    miscompares++;
                    $display("FAIL retry_count after 254 timeouts: retry=%0d required 254", retry_cnt);
                end
            end
        end
        vectors++;
        if (retry_cnt !== 8'd255 || relock_cnt !== 8'd255) begin
            miscompares++;
            $display("FAIL retry_sat: retry=%0d relock=%0d required 255 255", retry_cnt, relock_cnt);
        end
        $display("saturation: relock=%0d retry=%0d", relock_cnt, retry_cnt);
    endtask

    initial begin
        rst_n  = 1'b0;
        locked = 1'b0;
        test_reset();
        test_bringup();
        test_lock_timeout();
        test_filter_glitch();
        test_loss_run();
        test_reset_mid();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
